// File: rtl/writeback.sv
// Commit stage: retires executed instructions into the GPR file and EFLAGS,
// or drives byte-masked memory writes (two beats when crossing a word).
module writeback #(
  parameter logic [31:0] RESET_EFLAGS = 32'h0000_0002,
  parameter int          RETIRE_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_result,
  input  logic [31:0]         in_eflags,
  input  logic [1:0]          in_dst_kind,
  input  logic [2:0]          in_dst_reg,
  input  logic [1:0]          in_width,
  input  logic [31:0]         in_addr,
  input  logic [2:0]          rd_idx0,
  input  logic [2:0]          rd_idx1,
  output logic [31:0]         rd_data0,
  output logic [31:0]         rd_data1,
  output logic [31:0]         eflags_q,
  output logic                mem_wr_valid,
  input  logic                mem_wr_ready,
  output logic [31:0]         mem_wr_addr,
  output logic [31:0]         mem_wr_data,
  output logic [3:0]          mem_wr_be,
  output logic                retire_pulse,
  output logic [RETIRE_W-1:0] retire_count
);

  typedef enum logic [1:0] {IDLE, MEM0, MEM1} state_t;

  state_t      state, state_nxt;
  logic [31:0] gpr [8];
  logic [29:0] addr_q;
  logic [7:0]  sh_q;
  logic [63:0] dw_q;

  logic        accept, is_mem, is_gpr, retire;
  logic [3:0]  mask;
  logic [7:0]  sh;
  logic [63:0] dw;
  logic [2:0]  wr_idx;
  logic [31:0] wr_val;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = (in_dst_kind == 2'b10);
  assign is_gpr   = (in_dst_kind == 2'b01);
  assign rd_data0 = gpr[rd_idx0];
  assign rd_data1 = gpr[rd_idx1];

  // Lane placement for memory writes; the upper nibble/word is the spill beat.
  always_comb begin
    case (in_width)
      2'b00:   mask = 4'h1;
      2'b01:   mask = 4'h3;
      default: mask = 4'hF;
    endcase
    sh = {4'b0000, mask} << in_addr[1:0];
    dw = {32'b0, in_result} << {in_addr[1:0], 3'b000};
  end

  // 8-bit indices 4-7 name the high byte (AH..BH) of registers 0-3.
  always_comb begin
    wr_idx = (in_width == 2'b00) ? {1'b0, in_dst_reg[1:0]} : in_dst_reg;
    wr_val = gpr[wr_idx];
    case (in_width)
      2'b00: begin
        if (in_dst_reg[2]) wr_val[15:8] = in_result[7:0];
        else               wr_val[7:0]  = in_result[7:0];
      end
      2'b01:   wr_val[15:0] = in_result[15:0];
      default: wr_val       = in_result;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    retire       = 1'b0;
    mem_wr_valid = 1'b0;
    mem_wr_addr  = 32'h0;
    mem_wr_data  = 32'h0;
    mem_wr_be    = 4'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mem) state_nxt = MEM0;
          else        retire    = 1'b1;
        end
      end
      MEM0: begin
        mem_wr_valid = 1'b1;
        mem_wr_addr  = {addr_q, 2'b00};
        mem_wr_be    = sh_q[3:0];
        mem_wr_data  = dw_q[31:0];
        if (mem_wr_ready) begin
          if (|sh_q[7:4]) begin
            state_nxt = MEM1;
          end else begin
            state_nxt = IDLE;
            retire    = 1'b1;
          end
        end
      end
      MEM1: begin
        mem_wr_valid = 1'b1;
        mem_wr_addr  = {addr_q + 30'd1, 2'b00};
        mem_wr_be    = sh_q[7:4];
        mem_wr_data  = dw_q[63:32];
        if (mem_wr_ready) begin
          state_nxt = IDLE;
          retire    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      eflags_q     <= RESET_EFLAGS;
      addr_q       <= '0;
      sh_q         <= '0;
      dw_q         <= '0;
      retire_pulse <= 1'b0;
      retire_count <= '0;
      for (int i = 0; i < 8; i++) gpr[i] <= '0;
    end else begin
      state        <= state_nxt;
      retire_pulse <= retire;
      retire_count <= retire_count + RETIRE_W'(retire);
      if (accept) begin
        eflags_q <= in_eflags;
        if (is_gpr) gpr[wr_idx] <= wr_val;
        if (is_mem) begin
          addr_q <= in_addr[31:2];
          sh_q   <= sh;
          dw_q   <= dw;
        end
      end
    end
  end

endmodule
